// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: bus widths, arbiter state encoding
// and command constants.
package sdram_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned BA_W   = 2;

  // Command encoding is {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: fixed-priority grant (refresh > write > read) and
// command/address/data mux onto the shared SDRAM pins.
module sdram_arbit #(
  parameter int unsigned DATA_W = sdram_pkg::DATA_W,
  parameter int unsigned ADDR_W = sdram_pkg::ADDR_W,
  parameter int unsigned BA_W   = sdram_pkg::BA_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  import sdram_pkg::*;

  state_t     state_q, state_d;
  logic [3:0] cmd;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each grant only ends on its own *_end, so stray end pulses are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (init_end) state_d = ARBIT;
      end
      ARBIT: begin
        if (aref_req)    state_d = AREF;
        else if (wr_req) state_d = WRITE;
        else if (rd_req) state_d = READ;
      end
      AREF: begin
        if (aref_end) state_d = ARBIT;
      end
      WRITE: begin
        if (wr_end) state_d = ARBIT;
      end
      READ: begin
        if (rd_end) state_d = ARBIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants decode the registered state, so they rise on the edge that enters the state.
  assign aref_en = (state_q == AREF);
  assign wr_en   = (state_q == WRITE);
  assign rd_en   = (state_q == READ);

  always_comb begin
    cmd        = CMD_NOP;
    sdram_ba   = {BA_W{1'b1}};
    sdram_addr = {ADDR_W{1'b1}};
    unique case (state_q)
      IDLE: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd        = CMD_NOP;
        sdram_ba   = {BA_W{1'b1}};
        sdram_addr = {ADDR_W{1'b1}};
      end
    endcase
  end

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  assign sdram_dq = (state_q == WRITE && wr_sdram_en) ? wr_sdram_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: a directed sequence pushes the expected pin state
// per cycle, a negedge monitor pops and compares.
module tb_sdram_arbit;

  typedef enum int {SIdle, SArbit, SAref, SWrite, SRead} exp_st_t;

  typedef struct packed {
    logic [2:0]  gnt;   // {aref_en, wr_en, rd_en}
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq;
  } exp_t;

  localparam logic [15:0] TbDq   = 16'h3C3C;
  localparam logic [15:0] WrData = 16'hA5A5;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en;
  logic [3:0]  init_cmd = 4'b0010, aref_cmd = 4'b0001, wr_cmd = 4'b0100, rd_cmd = 4'b0101;
  logic [1:0]  init_ba = 2'b01, aref_ba = 2'b10, wr_ba = 2'b00, rd_ba = 2'b11;
  logic [12:0] init_addr = 13'h0400, aref_addr = 13'h0111, wr_addr = 13'h0222;
  logic [12:0] rd_addr = 13'h0333;
  logic [15:0] wr_sdram_data = WrData;
  logic        aref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n;
  logic        sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  wire  [15:0] sdram_dq;
  logic        tb_dq_en = 1'b1;

  // Bench drives a known pattern whenever the DUT is expected to release DQ.
  assign sdram_dq = tb_dq_en ? TbDq : 16'hzzzz;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  int   cyc_no = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
    .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq(sdram_dq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      $display("FAIL cycle %0d %s: got %h expected %h", cyc_no, name, act, req);
    end else begin
      n_pass++;
    end
  endtask

  // Expected pins for a hand-chosen state under the current stimulus.
  function automatic exp_t build(input exp_st_t st, input logic dq_drv);
    exp_t e;
    e.dq = dq_drv ? WrData : TbDq;
    case (st)
      SIdle:  begin e.gnt = 3'b000; e.cmd = 4'b0010; e.ba = 2'b01; e.addr = 13'h0400; end
      SArbit: begin e.gnt = 3'b000; e.cmd = 4'b0111; e.ba = 2'b11; e.addr = 13'h1fff; end
      SAref:  begin e.gnt = 3'b100; e.cmd = 4'b0001; e.ba = 2'b10; e.addr = 13'h0111; end
      SWrite: begin e.gnt = 3'b010; e.cmd = 4'b0100; e.ba = 2'b00; e.addr = 13'h0222; end
      default: begin e.gnt = 3'b001; e.cmd = 4'b0101; e.ba = 2'b11; e.addr = 13'h0333; end
    endcase
    return e;
  endfunction

  task automatic cyc(input exp_st_t st);
    logic drv;
    drv = (st == SWrite) && wr_sdram_en;
    tb_dq_en = !drv;
    exp_q.push_back(build(st, drv));
    @(posedge sys_clk);
    #1;
  endtask

  // Monitor: pins are combinational, so every cycle is an observation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("grants", {29'd0, aref_en, wr_en, rd_en}, {29'd0, e.gnt});
        check("cmd", {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, e.cmd});
        check("ba", {30'd0, sdram_ba}, {30'd0, e.ba});
        check("addr", {19'd0, sdram_addr}, {19'd0, e.addr});
        check("dq", {16'd0, sdram_dq}, {16'd0, e.dq});
        check("cke", {31'd0, sdram_cke}, 32'd1);
      end
      cyc_no++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en} = '0;
    @(posedge sys_clk);
    #1;
    cyc(SIdle);
    sys_rst_n = 1'b1;
    cyc(SIdle);
    cyc(SIdle);
    init_end = 1'b1;               cyc(SIdle);
    init_end = 1'b0;               cyc(SArbit);  // falling init_end is ignored
    // Write beats read when both requested together.
    wr_req = 1'b1; rd_req = 1'b1;  cyc(SArbit);
    wr_req = 1'b0; wr_sdram_en = 1'b1;
    cyc(SWrite);
    rd_end = 1'b1;                 cyc(SWrite);  // non-owner end ignored
    rd_end = 1'b0; wr_end = 1'b1;  cyc(SWrite);
    wr_end = 1'b0; wr_sdram_en = 1'b0;
    cyc(SArbit);
    rd_req = 1'b0; wr_sdram_en = 1'b1;
    cyc(SRead);                                  // write enable outside WRITE: no drive
    wr_sdram_en = 1'b0; wr_end = 1'b1;
    cyc(SRead);
    wr_end = 1'b0; aref_req = 1'b1;
    cyc(SRead);                                  // no preemption
    cyc(SRead);
    rd_end = 1'b1;                 cyc(SRead);
    rd_end = 1'b0;                 cyc(SArbit);
    aref_req = 1'b0;               cyc(SAref);
    aref_end = 1'b1;               cyc(SAref);
    aref_end = 1'b0;               cyc(SArbit);
    rd_end = 1'b1;                 cyc(SArbit);  // end pulse in ARBIT ignored
    rd_end = 1'b0;
    // All three at once: refresh, then write, then read.
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    cyc(SArbit);
    aref_req = 1'b0;               cyc(SAref);
    aref_end = 1'b1;               cyc(SAref);
    aref_end = 1'b0;               cyc(SArbit);
    wr_req = 1'b0;                 cyc(SWrite);
    wr_end = 1'b1;                 cyc(SWrite);
    wr_end = 1'b0;                 cyc(SArbit);
    rd_req = 1'b0;                 cyc(SRead);
    rd_end = 1'b1;                 cyc(SRead);
    rd_end = 1'b0; wr_req = 1'b1;  cyc(SArbit);
    wr_req = 1'b0; wr_sdram_en = 1'b1;
    cyc(SWrite);
    cyc(SWrite);
    // Asynchronous reset mid-write: observed before any further clock edge.
    sys_rst_n = 1'b0; wr_req = 1'b1;
    cyc(SIdle);
    sys_rst_n = 1'b1;
    cyc(SIdle);
    cyc(SIdle);
    cyc(SIdle);
    @(negedge sys_clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
